// File: rtl/lsu_access_sequencer.sv
// Load/store sequencer for a word-organised, byte-enabled, 1-cycle-read data memory.
// Steers byte lanes, splits word-crossing accesses into two beats and sign-extends loads.
module lsu_access_sequencer #(
    parameter int ADDR_W = 9
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req,
    input  logic              i_wren,
    input  logic [31:0]       i_addr,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    input  logic [31:0]       i_st_data,
    output logic              o_ready,
    output logic              o_done,
    output logic [31:0]       o_ld_data,
    output logic              o_split,
    output logic              o_mem_en,
    output logic              o_mem_wren,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_bmask,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    typedef enum logic [2:0] {IDLE, B0, B1, CAP, DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        size_q;
    logic              wren_q, signed_q;
    logic [31:0]       st_data_q, low_q;
    logic              accept;

    logic [1:0]        off;
    logic [3:0]        base;
    logic [7:0]        m8;
    logic [63:0]       w64, r64;
    logic [ADDR_W-1:0] idx0, idx1;
    logic [31:0]       ld_result;
    logic              unused_bits;

    function automatic logic needs_split(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return a == 2'd3;
            default: return a != 2'd0;
        endcase
    endfunction

    assign accept = i_req && (state == IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = B0;
            B0:   state_nx = o_split ? B1 : (wren_q ? DONE : CAP);
            B1:   state_nx = wren_q ? DONE : CAP;
            CAP:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Lane steering: everything derives from the latched request, never from live inputs.
    always_comb begin
        off = addr_q[1:0];
        case (size_q)
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
        m8   = {4'b0000, base} << off;
        w64  = {32'h0, st_data_q} << {off, 3'b000};
        idx0 = addr_q[ADDR_W+1:2];
        idx1 = idx0 + ADDR_W'(1);
    end

    // In CAP, i_mem_rdata holds the last beat's word: beat1 when split, otherwise beat0.
    always_comb begin
        r64 = (o_split ? {i_mem_rdata, low_q} : {32'h0, i_mem_rdata}) >> {off, 3'b000};
        case (size_q)
            2'b00:   ld_result = {{24{signed_q & r64[7]}},  r64[7:0]};
            2'b01:   ld_result = {{16{signed_q & r64[15]}}, r64[15:0]};
            default: ld_result = r64[31:0];
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            addr_q    <= '0;
            size_q    <= '0;
            wren_q    <= 1'b0;
            signed_q  <= 1'b0;
            st_data_q <= '0;
            low_q     <= '0;
            o_split   <= 1'b0;
            o_ld_data <= '0;
        end else begin
            if (accept) begin
                addr_q    <= i_addr[ADDR_W+1:0];
                size_q    <= i_size;
                wren_q    <= i_wren;
                signed_q  <= i_signed;
                st_data_q <= i_st_data;
                o_split   <= needs_split(i_size, i_addr[1:0]);
            end
            if (state == B1)
                low_q <= i_mem_rdata;
            if (state == CAP)
                o_ld_data <= ld_result;
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        o_ready     = (state == IDLE);
        o_done      = (state == DONE);
        o_mem_en    = 1'b0;
        o_mem_wren  = 1'b0;
        o_mem_addr  = '0;
        o_mem_bmask = 4'b0000;
        o_mem_wdata = 32'h0;
        case (state)
            B0: begin
                o_mem_en    = 1'b1;
                o_mem_wren  = wren_q;
                o_mem_addr  = idx0;
                o_mem_bmask = m8[3:0];
                o_mem_wdata = w64[31:0];
            end
            B1: begin
                o_mem_en    = 1'b1;
                o_mem_wren  = wren_q;
                o_mem_addr  = idx1;
                o_mem_bmask = m8[7:4];
                o_mem_wdata = w64[63:32];
            end
            default: ;
        endcase
    end

    assign unused_bits = ^{i_addr[31:ADDR_W+2], r64[63:32]};

endmodule

// File: tb/tb_lsu_access_sequencer.sv
// Directed self-checking bench for lsu_access_sequencer with a byte-enabled 1-cycle-read memory model.
module tb_lsu_access_sequencer;

    localparam int ADDR_W = 9;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_req = 1'b0;
    logic              i_wren = 1'b0;
    logic [31:0]       i_addr = '0;
    logic [1:0]        i_size = '0;
    logic              i_signed = 1'b0;
    logic [31:0]       i_st_data = '0;
    logic              o_ready, o_done, o_split;
    logic [31:0]       o_ld_data;
    logic              o_mem_en, o_mem_wren;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [3:0]        o_mem_bmask;
    logic [31:0]       o_mem_wdata;
    logic [31:0]       mem_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    // Results of the most recent access, filled by issue().
    int          nbeats, lat;
    logic        split1, busy_ready, ready_after;
    logic [31:0] beat_idx [0:3];
    logic [31:0] beat_mask [0:3];
    logic [31:0] beat_wdata [0:3];
    logic [31:0] beat_wren [0:3];
    logic [31:0] last_ld = '0;

    lsu_access_sequencer #(.ADDR_W(ADDR_W)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req       (i_req),
        .i_wren      (i_wren),
        .i_addr      (i_addr),
        .i_size      (i_size),
        .i_signed    (i_signed),
        .i_st_data   (i_st_data),
        .o_ready     (o_ready),
        .o_done      (o_done),
        .o_ld_data   (o_ld_data),
        .o_split     (o_split),
        .o_mem_en    (o_mem_en),
        .o_mem_wren  (o_mem_wren),
        .o_mem_addr  (o_mem_addr),
        .o_mem_bmask (o_mem_bmask),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_mem_en) begin
            if (o_mem_wren) begin
                for (int b = 0; b < 4; b++)
                    if (o_mem_bmask[b]) mem[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[o_mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] data, input logic hold);
        int waited = 0;
        nbeats = 0; lat = 0; busy_ready = 1'b0; split1 = 1'b0;
        while (!o_ready && waited < 10) begin
            @(negedge i_clk);
            waited++;
        end
        i_req = 1'b1; i_wren = wr; i_addr = addr; i_size = size;
        i_signed = sgn; i_st_data = data;
        @(posedge i_clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge i_clk);
            if (k == 1) begin
                // Scramble inputs: the access must run from latched values only.
                i_wren = ~wr; i_addr = ~addr; i_size = ~size;
                i_signed = ~sgn; i_st_data = ~data; i_req = hold;
                split1 = o_split;
            end
            if (o_mem_en) begin
                if (nbeats < 4) begin
                    beat_idx[nbeats]   = 32'(o_mem_addr);
                    beat_mask[nbeats]  = 32'(o_mem_bmask);
                    beat_wdata[nbeats] = o_mem_wdata;
                    beat_wren[nbeats]  = 32'(o_mem_wren);
                end
                nbeats++;
            end
            if (o_done) begin
                lat = k;
                i_req = 1'b0;
                break;
            end
            if (o_ready) busy_ready = 1'b1;
        end
        i_req = 1'b0;
        @(negedge i_clk);
        ready_after = o_ready;
    endtask

    task automatic run_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] data, input int n,
                             input logic [31:0] i0, input logic [31:0] m0, input logic [31:0] w0,
                             input logic [31:0] i1, input logic [31:0] m1, input logic [31:0] w1,
                             input int elat);
        issue(1'b1, addr, size, 1'b0, data, 1'b0);
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " beats"}, 32'(nbeats), 32'(n));
        check({tag, " split"}, 32'(split1), 32'(n == 2));
        check({tag, " b0 idx"}, beat_idx[0], i0);
        check({tag, " b0 mask"}, beat_mask[0], m0);
        check({tag, " b0 wdata"}, beat_wdata[0], w0);
        check({tag, " b0 wren"}, beat_wren[0], 32'd1);
        if (n == 2) begin
            check({tag, " b1 idx"}, beat_idx[1], i1);
            check({tag, " b1 mask"}, beat_mask[1], m1);
            check({tag, " b1 wdata"}, beat_wdata[1], w1);
        end
        check({tag, " ld_data kept"}, o_ld_data, last_ld);
        check({tag, " ready after"}, 32'(ready_after), 32'd1);
    endtask

    task automatic run_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic sgn, input logic [31:0] exp, input int n,
                            input int elat, input logic hold);
        issue(1'b0, addr, size, sgn, 32'h0, hold);
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " beats"}, 32'(nbeats), 32'(n));
        check({tag, " split"}, 32'(split1), 32'(n == 2));
        check({tag, " wren"}, beat_wren[0], 32'd0);
        check({tag, " data"}, o_ld_data, exp);
        if (hold) check({tag, " busy ready"}, 32'(busy_ready), 32'd0);
        last_ld = exp;
    endtask

    initial begin
        int stray;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst ready", 32'(o_ready), 32'd1);
        check("rst done", 32'(o_done), 32'd0);
        check("rst ld_data", o_ld_data, 32'h0);
        check("rst split", 32'(o_split), 32'd0);
        check("rst mem_en", 32'(o_mem_en), 32'd0);
        check("rst mem_wren", 32'(o_mem_wren), 32'd0);
        check("rst bmask", 32'(o_mem_bmask), 32'd0);
        check("rst maddr", 32'(o_mem_addr), 32'd0);
        check("rst wdata", o_mem_wdata, 32'h0);
        i_reset = 1'b0;
        @(negedge i_clk);

        run_store("sw 0x10", 32'h10, 2'b10, 32'hDEADBEEF, 1, 4, 4'hF, 32'hDEADBEEF, 0, 0, 0, 2);
        run_load("lw 0x10", 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 1, 3, 1'b0);
        run_store("sb 0x13", 32'h13, 2'b00, 32'h000000A5, 1, 4, 4'h8, 32'hA5000000, 0, 0, 0, 2);
        run_load("lb 0x13", 32'h13, 2'b00, 1'b1, 32'hFFFFFFA5, 1, 3, 1'b0);
        run_load("lbu 0x13", 32'h13, 2'b00, 1'b0, 32'h000000A5, 1, 3, 1'b0);
        run_store("sw 0x0E", 32'h0E, 2'b10, 32'h11223344, 2, 3, 4'hC, 32'h33440000,
                  4, 4'h3, 32'h00001122, 3);
        run_load("lw 0x0E", 32'h0E, 2'b10, 1'b0, 32'h11223344, 2, 4, 1'b0);
        run_store("sh 0x07", 32'h07, 2'b01, 32'h00008001, 2, 1, 4'h8, 32'h01000000,
                  2, 4'h1, 32'h00000080, 3);
        run_load("lh 0x07", 32'h07, 2'b01, 1'b1, 32'hFFFF8001, 2, 4, 1'b0);
        run_load("lhu 0x07", 32'h07, 2'b01, 1'b0, 32'h00008001, 2, 4, 1'b0);
        run_store("sh 0x05", 32'h05, 2'b01, 32'h00001234, 1, 1, 4'h6, 32'h00123400, 0, 0, 0, 2);
        run_load("lh 0x05", 32'h05, 2'b01, 1'b1, 32'h00001234, 1, 3, 1'b0);
        run_store("sw 0x7FE", 32'h7FE, 2'b10, 32'hCAFEF00D, 2, 511, 4'hC, 32'hF00D0000,
                  0, 4'h3, 32'h0000CAFE, 3);
        run_load("lw 0x7FE", 32'h7FE, 2'b10, 1'b0, 32'hCAFEF00D, 2, 4, 1'b0);
        run_store("s11 0x20", 32'h20, 2'b11, 32'h0BADCAFE, 1, 8, 4'hF, 32'h0BADCAFE, 0, 0, 0, 2);
        run_load("l11 0x20", 32'h20, 2'b11, 1'b0, 32'h0BADCAFE, 1, 3, 1'b0);
        run_load("lw hold 0x7FC", 32'h7FC, 2'b10, 1'b0, 32'hF00D0000, 1, 3, 1'b1);

        // Reset while the second beat of a split store is on the bus.
        i_req = 1'b1; i_wren = 1'b1; i_addr = 32'h0E; i_size = 2'b10; i_st_data = 32'h55667788;
        @(posedge i_clk);
        @(negedge i_clk);
        i_req = 1'b0;
        check("rstmid b0 en", 32'(o_mem_en), 32'd1);
        @(negedge i_clk);
        check("rstmid b1 mask", 32'(o_mem_bmask), 32'h3);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        check("rstmid mem_en", 32'(o_mem_en), 32'd0);
        check("rstmid done", 32'(o_done), 32'd0);
        check("rstmid ready", 32'(o_ready), 32'd1);
        check("rstmid split", 32'(o_split), 32'd0);
        check("rstmid ld_data", o_ld_data, 32'h0);
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            if (o_mem_en || o_done) stray++;
        end
        check("rstmid stray activity", 32'(stray), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_access_sequencer.md
Name: lsu_access_sequencer

Overview:
- Sits between the pipeline's load/store request and a single-port, word-organised data memory with byte-enables and 1-cycle synchronous read.
- Performs byte-lane steering, byte-mask generation and load sign-extension.
- Splits any access that crosses a 32-bit word boundary into two sequenced memory beats.
- Stalls the requester through a ready/done handshake until the access completes.
- Address decode (memory vs PIO) is upstream; this block only sees data-memory accesses.

Parameters:
- ADDR_W, 9, word-index width of the memory (512 words = 2 KiB).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req  in  1  access request.
- i_wren  in  1  1 = store, 0 = load.
- i_addr  in  32  byte address; only bits [ADDR_W+1:0] are used.
- i_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- i_signed  in  1  sign-extend loaded byte/half.
- i_st_data  in  32  store data, right-justified.
- o_ready  out  1  block idle; a request is accepted when i_req & o_ready.
- o_done  out  1  one-cycle completion pulse.
- o_ld_data  out  32  load result; valid with o_done, held until the next load's o_done.
- o_split  out  1  registered; current access needs two beats.
- o_mem_en  out  1  memory access this cycle.
- o_mem_wren  out  1  write enable (only when o_mem_en).
- o_mem_addr  out  ADDR_W  word index.
- o_mem_bmask  out  4  byte enables.
- o_mem_wdata  out  32  lane-aligned write data.
- i_mem_rdata  in  32  read data for the word addressed in the previous cycle.

Behaviour:
- Reset (synchronous, i_reset high at a clock edge): state IDLE.
  - o_ready=1; o_done=0; o_ld_data=0; o_split=0.
  - o_mem_en=0, o_mem_wren=0, o_mem_bmask=0, o_mem_addr=0, o_mem_wdata=0.
- Reset during any state abandons the access: no further memory beat is issued, and no o_done.
- States: IDLE, B0, B1, CAP, DONE.
- o_ready=1 only in IDLE. i_req in any other state is ignored; the requester holds the request until accepted.
- On accept, latch addr, size, wren, signed and st_data. Input changes after accept have no effect.
- Split rule: off = addr[1:0].
  - Word with off≠0 is split.
  - Half with off=3 is split; half at off=1 is NOT split.
  - Bytes are never split.
- Lane math:
  - base = 0001 / 0011 / 1111 for byte / half / word.
  - m8 = base << off, computed 8 bits wide.
  - Beat0 bmask = m8[3:0]; beat1 bmask = m8[7:4].
  - w64 = zero-extended st_data << (8·off).
  - Beat0 wdata = w64[31:0]; beat1 wdata = w64[63:32].
- Word index:
  - Beat0 idx = addr[ADDR_W+1:2].
  - Beat1 idx = idx+1 mod 2^ADDR_W; the top word wraps to 0.
- Transitions:
  - IDLE → B0 on accept.
  - B0 → B1 if split.
  - B0 → CAP if load and not split.
  - B0 → DONE if store and not split.
  - B1 → CAP if load, → DONE if store.
  - CAP → DONE.
  - DONE → IDLE.
- Memory outputs: o_mem_en=1 only in B0/B1, with o_mem_wren = latched wren. In all other states, en/wren/bmask are 0.
- Load capture:
  - The beat0 word (valid in the cycle after B0) goes into a low register; the beat1 word goes into a high register.
  - An unsplit access uses high=0.
  - r64 = {high, low} >> (8·off).
  - Result = r64[7:0], r64[15:0] or r64[31:0] per size, sign-extended from bit 7/15 when i_signed, else zero-extended.
  - o_ld_data is registered on entry to DONE.
- Stores leave o_ld_data unchanged.
- Latency (accept at edge T, o_done high in cycle):
  - aligned store T+2
  - split store T+3
  - aligned load T+3
  - split load T+4
- o_ready returns high in the cycle after o_done; minimum issue interval is therefore latency+1.

Test Plan:
- Aligned word store: addr 0x10, data 0xDEADBEEF → one beat, idx 4, bmask 1111, wdata 0xDEADBEEF; o_done at T+2.
- Aligned word load: read back 0x10 → o_ld_data 0xDEADBEEF at T+3.
- Byte store, then signed/unsigned byte loads:
  - Store addr 0x13, data 0x000000A5 → idx 4, bmask 1000, wdata 0xA5000000.
  - Signed lb 0x13 → 0xFFFFFFA5; unsigned lbu → 0x000000A5.
- Split word store:
  - addr 0x0E, data 0x11223344 → beat0 idx 3, bmask 1100, wdata 0x33440000; beat1 idx 4, bmask 0011, wdata 0x00001122; o_done at T+3.
  - Load 0x0E → 0x11223344 at T+4.
- Halves:
  - Half at offset 3 (addr 0x07, data 0x8001) → split beats bmask 1000 / 0001; signed lh → 0xFFFF8001.
  - Half at offset 1 (addr 0x05) → one beat, bmask 0110.
- Boundary and reset:
  - Word store at byte addr 0x7FE → beat1 idx wraps 511 → 0.
  - Assert i_reset during B1 of a split store → no beat in the following cycle, no o_done, o_ready=1 after reset.
  - i_req held high while busy → no second accept until IDLE.
